// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard for pending writebacks.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy to the read ports.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_sel,
  output logic [WIDTH-1:0]  rs1_value,
  output logic              rs1_busy,
  input  logic [ADDR_W-1:0] rs2_sel,
  output logic [WIDTH-1:0]  rs2_value,
  output logic              rs2_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [WIDTH-1:0]  wr_value,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_sel,
  input  logic              flush,
  output logic              any_busy
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            wr_hit, rsv_hit;
  logic                        wr_ok, rsv_ok;
  logic [WIDTH-1:0]            arr1_val, arr2_val;
  logic                        arr1_busy, arr2_busy;

  // x0 (when hardwired) and out-of-range selects never produce a hit,
  // so those registers keep their reset value of zero.
  function automatic logic sel_ok(input logic [ADDR_W-1:0] s);
    return ({1'b0, s} < DEPTH_L) && !((ZERO_REG != 0) && (s == '0));
  endfunction

  assign wr_ok  = wr_en  && sel_ok(wr_sel);
  assign rsv_ok = rsv_en && sel_ok(rsv_sel);

  for (genvar g = 0; g < DEPTH; g++) begin : g_dec
    assign wr_hit[g]  = wr_ok  && (wr_sel  == ADDR_W'(g));
    assign rsv_hit[g] = rsv_ok && (rsv_sel == ADDR_W'(g));
  end

  // Priority for busy: flush > reserve (newer instruction) > writeback clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) regs[i] <= wr_value;
        busy[i] <= !flush && (rsv_hit[i] || (busy[i] && !wr_hit[i]));
      end
    end
  end

  always_comb begin
    arr1_val  = '0;
    arr1_busy = 1'b0;
    arr2_val  = '0;
    arr2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs1_sel == ADDR_W'(i)) begin
        arr1_val  = regs[i];
        arr1_busy = busy[i];
      end
      if (rs2_sel == ADDR_W'(i)) begin
        arr2_val  = regs[i];
        arr2_busy = busy[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2, keep1, keep2;
  assign fwd1  = wr_ok && (rs1_sel == wr_sel);
  assign fwd2  = wr_ok && (rs2_sel == wr_sel);
  assign keep1 = rsv_ok && (rsv_sel == rs1_sel) && !flush;
  assign keep2 = rsv_ok && (rsv_sel == rs2_sel) && !flush;

  assign rs1_value = fwd1 ? wr_value : arr1_val;
  assign rs1_busy  = fwd1 ? keep1    : arr1_busy;
  assign rs2_value = fwd2 ? wr_value : arr2_val;
  assign rs2_busy  = fwd2 ? keep2    : arr2_busy;
`else
  assign rs1_value = arr1_val;
  assign rs1_busy  = arr1_busy;
  assign rs2_value = arr2_val;
  assign rs2_busy  = arr2_busy;
`endif

  assign any_busy = |busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + randomized checks of regfile_scoreboard against an array/flag reference model.
module tb_regfile_scoreboard;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_sel, rs2_sel, wr_sel, rsv_sel;
  logic [31:0] wr_value, rs1_value, rs2_value;
  logic        wr_en, rsv_en, flush, rs1_busy, rs2_busy, any_busy;

  logic [3:0]  b_rs1_sel, b_rs2_sel, b_wr_sel, b_rsv_sel;
  logic [31:0] b_wr_value, b_rs1_value, b_rs2_value;
  logic        b_wr_en, b_rsv_en, b_flush, b_rs1_busy, b_rs2_busy, b_any_busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_val [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_sel(rs1_sel), .rs1_value(rs1_value), .rs1_busy(rs1_busy),
    .rs2_sel(rs2_sel), .rs2_value(rs2_value), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_value(wr_value),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush), .any_busy(any_busy)
  );

  regfile_scoreboard #(.WIDTH(32), .DEPTH(12), .ADDR_W(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rs1_sel(b_rs1_sel), .rs1_value(b_rs1_value), .rs1_busy(b_rs1_busy),
    .rs2_sel(b_rs2_sel), .rs2_value(b_rs2_value), .rs2_busy(b_rs2_busy),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_value(b_wr_value),
    .rsv_en(b_rsv_en), .rsv_sel(b_rsv_sel), .flush(b_flush), .any_busy(b_any_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_valid(input int s);
    return (s < D) && (s != 0);
  endfunction

  function automatic bit fwd_hit(input int s);
`ifdef REGFILE_BYPASS_EN
    return wr_en && m_valid(int'(wr_sel)) && (int'(wr_sel) == s);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_val(input int s);
    if (!m_valid(s)) return 32'h0;
    if (fwd_hit(s))  return wr_value;
    return m_val[s];
  endfunction

  function automatic logic [31:0] exp_busy(input int s);
    if (!m_valid(s)) return 32'h0;
    if (fwd_hit(s))  return {31'h0, rsv_en && (int'(rsv_sel) == s) && !flush};
    return {31'h0, m_busy[s]};
  endfunction

  function automatic logic [31:0] exp_any();
    bit a = 1'b0;
    for (int i = 0; i < 32; i++) a |= m_busy[i];
    return {31'h0, a};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_val[i] = 32'h0; m_busy[i] = 1'b0; end
  endtask

  task automatic check_all();
    chk("rs1_value", rs1_value, exp_val(int'(rs1_sel)));
    chk("rs1_busy", {31'h0, rs1_busy}, exp_busy(int'(rs1_sel)));
    chk("rs2_value", rs2_value, exp_val(int'(rs2_sel)));
    chk("rs2_busy", {31'h0, rs2_busy}, exp_busy(int'(rs2_sel)));
    chk("any_busy", {31'h0, any_busy}, exp_any());
  endtask

  // Apply the edge rules to the model using the inputs held across the edge.
  task automatic edge_a();
    @(posedge clk);
    if (wr_en && m_valid(int'(wr_sel))) begin
      m_val[wr_sel]  = wr_value;
      m_busy[wr_sel] = 1'b0;
    end
    if (rsv_en && m_valid(int'(rsv_sel))) m_busy[rsv_sel] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    #1;
  endtask

  task automatic cyc();
    #1;
    check_all();
    edge_a();
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_sel = 5'd5; rs2_sel = 5'd7; wr_sel = '0; rsv_sel = '0; wr_value = '0;
    idle();
    b_rs1_sel = '0; b_rs2_sel = '0; b_wr_sel = '0; b_rsv_sel = '0; b_wr_value = '0;
    b_wr_en = 1'b0; b_rsv_en = 1'b0; b_flush = 1'b0;
    m_reset();
    #2;
    chk("reset_rs1_value", rs1_value, 32'h0);
    chk("reset_any_busy", {31'h0, any_busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-operation clears data and busy without a clock edge.
    wr_en = 1'b1; wr_sel = 5'd5; wr_value = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_sel = 5'd6;
    cyc();
    idle();
    #1;
    chk("x5_written", rs1_value, 32'hDEADBEEF);
    chk("x6_busy_any", {31'h0, any_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_value", rs1_value, 32'h0);
    chk("async_rst_any", {31'h0, any_busy}, 32'h0);
    m_reset();
    #1 rst_n = 1'b1;
    edge_a();

    // x0 is never written or reserved.
    rs1_sel = 5'd0;
    wr_en = 1'b1; wr_sel = 5'd0; wr_value = 32'h12345678;
    rsv_en = 1'b1; rsv_sel = 5'd0;
    cyc();
    idle();
    #1;
    chk("x0_value", rs1_value, 32'h0);
    chk("x0_busy", {31'h0, rs1_busy}, 32'h0);
    chk("x0_any", {31'h0, any_busy}, 32'h0);

    // Scoreboard: reserve x7, three idle cycles, then writeback.
    rs2_sel = 5'd7;
    rsv_en = 1'b1; rsv_sel = 5'd7;
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sb_idle_busy", {31'h0, rs2_busy}, 32'h1);
      check_all();
      edge_a();
    end
    wr_en = 1'b1; wr_sel = 5'd7; wr_value = 32'h000000AA;
    cyc();
    idle();
    #1;
    chk("sb_done_busy", {31'h0, rs2_busy}, 32'h0);
    chk("sb_done_value", rs2_value, 32'h000000AA);

    // Simultaneous write and reserve of x3; reservation wins busy.
    rs1_sel = 5'd3;
    wr_en = 1'b1; wr_sel = 5'd3; wr_value = 32'h55;
    rsv_en = 1'b1; rsv_sel = 5'd3;
    cyc();
    idle();
    #1;
    chk("wr_rsv_value", rs1_value, 32'h55);
    chk("wr_rsv_busy", {31'h0, rs1_busy}, 32'h1);
    rsv_en = 1'b1; rsv_sel = 5'd3;  cyc();
    rsv_sel = 5'd9;                 cyc();
    rsv_sel = 5'd15; flush = 1'b1;  cyc();
    idle();
    #1;
    chk("flush_any", {31'h0, any_busy}, 32'h0);

    // Same-cycle read of the register being written back.
    wr_en = 1'b1; wr_sel = 5'd4; wr_value = 32'h11; cyc();
    idle(); rsv_en = 1'b1; rsv_sel = 5'd4; cyc();
    idle();
    rs1_sel = 5'd4; wr_en = 1'b1; wr_sel = 5'd4; wr_value = 32'h22;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_value", rs1_value, 32'h22);
    chk("bypass_busy", {31'h0, rs1_busy}, 32'h0);
`else
    chk("nobypass_value", rs1_value, 32'h11);
    chk("nobypass_busy", {31'h0, rs1_busy}, 32'h1);
`endif
    cyc();
    idle();

    // Randomized traffic, including out-of-range and x0 selects.
    for (int n = 0; n < 400; n++) begin
      rs1_sel  = 5'($urandom_range(0, 31));
      rs2_sel  = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, 31));
      wr_en    = 1'($urandom_range(0, 1));
      wr_sel   = 5'($urandom_range(0, 19));
      wr_value = $urandom;
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_sel  = ($urandom_range(0, 3) == 0) ? wr_sel : 5'($urandom_range(0, 19));
      flush    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 2) == 0) rs1_sel = wr_sel;
      cyc();
    end
    idle();

    // Non-power-of-two depth: selector 13 is out of range.
    for (int i = 1; i < 12; i++) begin
      b_wr_en = 1'b1; b_wr_sel = 4'(i); b_wr_value = 32'h100 + i;
      @(posedge clk); #1;
    end
    b_wr_sel = 4'd13; b_wr_value = 32'hFF; b_rsv_en = 1'b1; b_rsv_sel = 4'd13;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rsv_en = 1'b0; b_rs1_sel = 4'd13;
    #1;
    chk("oor_value", b_rs1_value, 32'h0);
    chk("oor_busy", {31'h0, b_rs1_busy}, 32'h0);
    chk("oor_any", {31'h0, b_any_busy}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      b_rs2_sel = 4'(i);
      #1;
      chk("d12_unchanged", b_rs2_value, (i == 0) ? 32'h0 : 32'h100 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
